// File: rtl/di_branch_hazard_unit.sv
// ID-stage branch hazard unit: load/ALU stalls via a 3-state FSM plus comparator forwarding selects.
// Outputs are combinational, with no added latency. Optional stall counter under BRANCH_STALL_CNT_EN.
module di_branch_hazard_unit #(
  parameter int                  REG_ADDR_W = 5,
  parameter int                  OPCODE_W   = 6,
  parameter logic [OPCODE_W-1:0] BEQ_OP     = 6'b000100,
  parameter logic [OPCODE_W-1:0] BNE_OP     = 6'b000101,
  parameter int                  CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  idex_reg_write,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_write_reg,
  input  logic                  exme_reg_write,
  input  logic                  exme_mem_read,
  input  logic [REG_ADDR_W-1:0] exme_write_reg,
  input  logic                  mewb_reg_write,
  input  logic [REG_ADDR_W-1:0] mewb_write_reg,
  input  logic                  cnt_clr,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall
`ifdef BRANCH_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, STALL2, STALL1} state_t;

  state_t state_q, state_d;
  logic   is_branch;
  logic   h1, h2;
  logic   idex_rs_dep, idex_rt_dep, exme_rs_dep, exme_rt_dep, mewb_rs_dep, mewb_rt_dep;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic dep(input logic [REG_ADDR_W-1:0] src,
                               input logic                  we,
                               input logic [REG_ADDR_W-1:0] dst);
    return (src != '0) && we && (src == dst);
  endfunction

  assign is_branch   = id_valid && ((id_opcode == BEQ_OP) || (id_opcode == BNE_OP));
  assign idex_rs_dep = dep(id_rs, idex_reg_write, idex_write_reg);
  assign idex_rt_dep = dep(id_rt, idex_reg_write, idex_write_reg);
  assign exme_rs_dep = dep(id_rs, exme_reg_write, exme_write_reg);
  assign exme_rt_dep = dep(id_rt, exme_reg_write, exme_write_reg);
  assign mewb_rs_dep = dep(id_rs, mewb_reg_write, mewb_write_reg);
  assign mewb_rt_dep = dep(id_rt, mewb_reg_write, mewb_write_reg);

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    h2 = is_branch && idex_mem_read && (idex_rs_dep || idex_rt_dep);
    h1 = is_branch && ((!idex_mem_read && (idex_rs_dep || idex_rt_dep)) ||
                       (exme_mem_read && (exme_rs_dep || exme_rt_dep)));

    case (state_q)
      IDLE: begin
        if (h2) state_d = STALL2;
        else if (h1) state_d = STALL1;
      end
      STALL2:  state_d = STALL1;
      STALL1:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Held reset masks the stall so an aborted stall is visible at once.
    stall = rst_n && ((state_q != IDLE) || h1 || h2);

    if (is_branch && !stall) begin
      if (exme_rs_dep && !exme_mem_read) fwd_a_sel = 2'b10;
      else if (mewb_rs_dep)              fwd_a_sel = 2'b11;
      if (exme_rt_dep && !exme_mem_read) fwd_b_sel = 2'b10;
      else if (mewb_rt_dep)              fwd_b_sel = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef BRANCH_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                    cnt_d = '0;
    else if (stall && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_di_branch_hazard_unit.sv
// Directed and randomized bench for di_branch_hazard_unit against a countdown-style reference model.
module tb_di_branch_hazard_unit;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt;
  logic       idex_reg_write, idex_mem_read;
  logic [4:0] idex_write_reg;
  logic       exme_reg_write, exme_mem_read;
  logic [4:0] exme_write_reg;
  logic       mewb_reg_write;
  logic [4:0] mewb_write_reg;
  logic       cnt_clr, cnt_clr2;
  logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a2, fwd_b2;
  logic       stall, stall2;

  int checks = 0;
  int errors = 0;
  int left   = 0;      // model: stall cycles still owed after this one
  int m_cnt  = 0;
  int m_cnt2 = 0;
  bit track2 = 1'b1;

  always #5 clk = ~clk;

`ifdef BRANCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;
`endif

  di_branch_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt),
    .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read), .idex_write_reg(idex_write_reg),
    .exme_reg_write(exme_reg_write), .exme_mem_read(exme_mem_read), .exme_write_reg(exme_write_reg),
    .mewb_reg_write(mewb_reg_write), .mewb_write_reg(mewb_write_reg),
    .cnt_clr(cnt_clr), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall)
`ifdef BRANCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  di_branch_hazard_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt),
    .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read), .idex_write_reg(idex_write_reg),
    .exme_reg_write(exme_reg_write), .exme_mem_read(exme_mem_read), .exme_write_reg(exme_write_reg),
    .mewb_reg_write(mewb_reg_write), .mewb_write_reg(mewb_write_reg),
    .cnt_clr(cnt_clr2), .fwd_a_sel(fwd_a2), .fwd_b_sel(fwd_b2), .stall(stall2)
`ifdef BRANCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mdep(input logic [4:0] src, input logic we, input logic [4:0] dst);
    return src != 0 && we && src == dst;
  endfunction

  function automatic bit m_branch();
    return id_valid && (id_opcode == BEQ || id_opcode == BNE);
  endfunction

  function automatic int m_class();  // 2 = load-use in ID/EX, 1 = one-cycle hazard, 0 = none
    bit ie, ee;
    ie = mdep(id_rs, idex_reg_write, idex_write_reg) || mdep(id_rt, idex_reg_write, idex_write_reg);
    ee = mdep(id_rs, exme_reg_write, exme_write_reg) || mdep(id_rt, exme_reg_write, exme_write_reg);
    if (!m_branch()) return 0;
    if (ie && idex_mem_read) return 2;
    if ((ie && !idex_mem_read) || (ee && exme_mem_read)) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] m_sel(input logic [4:0] src, input bit st);
    if (!m_branch() || st) return 2'b00;
    if (mdep(src, exme_reg_write, exme_write_reg) && !exme_mem_read) return 2'b10;
    if (mdep(src, mewb_reg_write, mewb_write_reg)) return 2'b11;
    return 2'b00;
  endfunction

  // Compare against the model, then advance one clock; enters and exits at a falling edge.
  task automatic cycle();
    int cls;
    bit st;
    cls = m_class();
    st  = rst_n && (left > 0 || cls != 0);
    #1;
    chk("model_stall", {31'd0, stall}, {31'd0, st});
    chk("model_fwd_a", {30'd0, fwd_a_sel}, {30'd0, m_sel(id_rs, st)});
    chk("model_fwd_b", {30'd0, fwd_b_sel}, {30'd0, m_sel(id_rt, st)});
`ifdef BRANCH_STALL_CNT_EN
    chk("model_cnt", {16'd0, stall_cnt}, m_cnt);
`endif
    @(posedge clk);
    left  = (left > 0) ? left - 1 : cls;
    m_cnt = cnt_clr ? 0 : (st && m_cnt < 16'hffff) ? m_cnt + 1 : m_cnt;
    if (st && m_cnt2 < 3) m_cnt2++;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_opcode = 0; id_rs = 0; id_rt = 0;
    idex_reg_write = 0; idex_mem_read = 0; idex_write_reg = 0;
    exme_reg_write = 0; exme_mem_read = 0; exme_write_reg = 0;
    mewb_reg_write = 0; mewb_write_reg = 0; cnt_clr = 0;
  endtask

  initial begin
    clear_inputs();
    cnt_clr2 = 0;
    rst_n = 0; rst2_n = 0;
    #1;
    chk("reset_stall", {31'd0, stall}, 0);
    chk("reset_fwd_a", {30'd0, fwd_a_sel}, 0);
`ifdef BRANCH_STALL_CNT_EN
    chk("reset_cnt", {16'd0, stall_cnt}, 0);
`endif
    @(posedge clk); @(negedge clk);
    rst_n = 1; rst2_n = 1;

    // Load feeding a BEQ: three stall cycles, then MEM/WB forward on rs.
    id_valid = 1; id_opcode = BEQ; id_rs = 8; id_rt = 3;
    idex_reg_write = 1; idex_mem_read = 1; idex_write_reg = 8;
    #1 chk("ld_stall_idle", {31'd0, stall}, 1);
    cycle();
    idex_reg_write = 0; idex_mem_read = 0; idex_write_reg = 0;
    exme_reg_write = 1; exme_mem_read = 1; exme_write_reg = 8;
    #1 chk("ld_stall_s2", {31'd0, stall}, 1);
    cycle();
    exme_reg_write = 0; exme_mem_read = 0; exme_write_reg = 0;
    mewb_reg_write = 1; mewb_write_reg = 8;
    #1 chk("ld_stall_s1", {31'd0, stall}, 1);
    chk("ld_sel_during_stall", {30'd0, fwd_a_sel}, 0);
    cycle();
    #1 chk("ld_release", {31'd0, stall}, 0);
    chk("ld_fwd_a_mewb", {30'd0, fwd_a_sel}, 2'b11);
    cycle();
`ifdef BRANCH_STALL_CNT_EN
    chk("cnt2_after_ld", {30'd0, stall_cnt2}, 3);
`endif

    // ALU result feeding a BNE on rt: two stall cycles, then EX/MEM forward.
    clear_inputs();
    id_valid = 1; id_opcode = BNE; id_rs = 1; id_rt = 9;
    idex_reg_write = 1; idex_write_reg = 9;
    #1 chk("alu_stall_idle", {31'd0, stall}, 1);
    cycle();
    idex_reg_write = 0; idex_write_reg = 0;
    exme_reg_write = 1; exme_write_reg = 9;
    #1 chk("alu_stall_s1", {31'd0, stall}, 1);
    cycle();
    #1 chk("alu_release", {31'd0, stall}, 0);
    chk("alu_fwd_b_exme", {30'd0, fwd_b_sel}, 2'b10);
    cycle();
`ifdef BRANCH_STALL_CNT_EN
    chk("cnt_after_two", {16'd0, stall_cnt}, 5);
    chk("cnt2_saturated", {30'd0, stall_cnt2}, 3);
`endif
    track2 = 0;

    // Clear coinciding with a stalling cycle.
    clear_inputs();
    id_valid = 1; id_opcode = BEQ; id_rs = 2;
    idex_reg_write = 1; idex_write_reg = 2; cnt_clr = 1;
    cycle();
`ifdef BRANCH_STALL_CNT_EN
    chk("cnt_clr_wins", {16'd0, stall_cnt}, 0);
`endif
    clear_inputs();
    cycle();

    // Register 0 everywhere never hazards or forwards.
    id_valid = 1; id_opcode = BEQ;
    idex_reg_write = 1; idex_mem_read = 1; exme_reg_write = 1; mewb_reg_write = 1;
    #1 chk("r0_stall", {31'd0, stall}, 0);
    chk("r0_fwd_a", {30'd0, fwd_a_sel}, 0);
    chk("r0_fwd_b", {30'd0, fwd_b_sel}, 0);
    cycle();

    // EX/MEM beats MEM/WB.
    clear_inputs();
    id_valid = 1; id_opcode = BEQ; id_rs = 12;
    exme_reg_write = 1; exme_write_reg = 12; mewb_reg_write = 1; mewb_write_reg = 12;
    #1 chk("prio_stall", {31'd0, stall}, 0);
    chk("prio_fwd_a", {30'd0, fwd_a_sel}, 2'b10);
    cycle();

    // Reset in the middle of a load stall.
    clear_inputs();
    id_valid = 1; id_opcode = BEQ; id_rs = 8;
    idex_reg_write = 1; idex_mem_read = 1; idex_write_reg = 8;
    cycle();
    rst_n = 0; left = 0; m_cnt = 0;
    #1 chk("abort_stall", {31'd0, stall}, 0);
`ifdef BRANCH_STALL_CNT_EN
    chk("abort_cnt", {16'd0, stall_cnt}, 0);
`endif
    @(posedge clk); @(negedge clk);
    rst_n = 1; id_opcode = 6'b000000;
    #1 chk("nonbranch_stall", {31'd0, stall}, 0);
    chk("nonbranch_fwd_a", {30'd0, fwd_a_sel}, 0);
    cycle();
    #1 chk("post_abort_idle", {31'd0, stall}, 0);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      int pick;
      pick = $urandom_range(0, 5);
      id_valid  = ($urandom_range(0, 7) != 0);
      id_opcode = (pick < 2) ? BEQ : (pick < 4) ? BNE : (pick == 4) ? 6'd0 : 6'($urandom);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      idex_reg_write = 1'($urandom); idex_mem_read = 1'($urandom);
      idex_write_reg = 5'($urandom_range(0, 3));
      exme_reg_write = 1'($urandom); exme_mem_read = 1'($urandom);
      exme_write_reg = 5'($urandom_range(0, 3));
      mewb_reg_write = 1'($urandom); mewb_write_reg = 5'($urandom_range(0, 3));
      cnt_clr = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
